// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath/debug bundle for the 8-bit accumulator CPU.
// master drives control inputs; slave is the sequencer.
interface cpu_sequencer_if #(
  parameter int PC_WIDTH     = 5,
  parameter int OPCODE_WIDTH = 4
);
  logic                    run;
  logic                    step_req;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [PC_WIDTH-1:0]     jmp_target;
  logic                    acc_zero;
  logic [PC_WIDTH-1:0]     pc;
  logic                    ir_ce;
  logic                    ld_ce;
  logic                    st_ce;
  logic                    acc_ce;
  logic                    cy_ce;
  logic                    step_done;
  logic                    halted;
  logic [7:0]              retired;

  modport master (
    output run, step_req, opcode,
    output jmp_target, acc_zero,
    input  pc, ir_ce, ld_ce, st_ce,
    input  acc_ce, cy_ce, step_done,
    input  halted, retired
  );

  modport slave (
    input  run, step_req, opcode,
    input  jmp_target, acc_zero,
    output pc, ir_ce, ld_ce, st_ce,
    output acc_ce, cy_ce, step_done,
    output halted, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC control unit with PC,
// free-run, single-step and HALT.
module cpu_sequencer #(
  parameter int PC_WIDTH     = 5,
  parameter int OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_NOP  = 4'h0,
  parameter logic [OPCODE_WIDTH-1:0] OP_LD   = 4'h1,
  parameter logic [OPCODE_WIDTH-1:0] OP_ST   = 4'h2,
  parameter logic [OPCODE_WIDTH-1:0] OP_JMP  = 4'hC,
  parameter logic [OPCODE_WIDTH-1:0] OP_JZ   = 4'hD,
  parameter logic [OPCODE_WIDTH-1:0] OP_HALT = 4'hF
) (
  input logic      clk,
  input logic      rst_n,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          ret_q, ret_d;
  logic                step_q, step_d;
  logic                done_q, done_d;

  logic is_nop, is_ld, is_st;
  logic is_jmp, is_jz, is_halt, is_alu;
  logic ir_ce, ld_ce, st_ce, acc_ce, cy_ce;

  always_comb begin
    is_nop  = (bus.opcode == OP_NOP);
    is_ld   = (bus.opcode == OP_LD);
    is_st   = (bus.opcode == OP_ST);
    is_jmp  = (bus.opcode == OP_JMP);
    is_jz   = (bus.opcode == OP_JZ);
    is_halt = (bus.opcode == OP_HALT);
    is_alu  = !(is_nop | is_ld | is_st |
                is_jmp | is_jz | is_halt);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    step_d  = step_q;
    done_d  = 1'b0;
    ir_ce   = 1'b0;
    ld_ce   = 1'b0;
    st_ce   = 1'b0;
    acc_ce  = 1'b0;
    cy_ce   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
        end else if (bus.step_req) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        ir_ce   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        ld_ce  = is_ld;
        st_ce  = is_st;
        acc_ce = is_alu;
        cy_ce  = is_alu;
        if (is_halt) begin
          state_d = S_HALT;
        end else begin
          ret_d = ret_q + 8'd1;
          pc_d  = pc_q + PC_WIDTH'(1);
          if (is_jmp || (is_jz && bus.acc_zero))
            pc_d = bus.jmp_target;
          // a step-mode instruction always returns to IDLE
          if (bus.run && !step_q) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
            done_d  = step_q;
            step_d  = 1'b0;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.retired   = ret_q;
  assign bus.step_done = done_q;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.ir_ce     = ir_ce;
  assign bus.ld_ce     = ld_ce;
  assign bus.st_ce     = st_ce;
  assign bus.acc_ce    = acc_ce;
  assign bus.cy_ce     = cy_ce;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios plus random
// run/step/reset traffic against an instruction-level model.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [3:0] rom_op [32];
  logic [4:0] rom_tg [32];

  assign bus.opcode     = rom_op[bus.pc];
  assign bus.jmp_target = rom_tg[bus.pc];

  int checks = 0;
  int errors = 0;

  // model: busy with an instruction of age 0/1/2 cycles
  bit busy, mstep, mhalt, mdone, chk_en;
  int age, mpc, mret;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s,
                     input bit z, input bit rn);
    bit ex, e_ir, e_ld, e_st, e_alu;
    int op;
    @(negedge clk);
    bus.run      = r;
    bus.step_req = s;
    bus.acc_zero = z;
    rst_n        = rn;
    #1;
    ex    = busy && age == 2;
    op    = int'(rom_op[mpc]);
    e_ir  = busy && age == 0;
    e_ld  = ex && op == 1;
    e_st  = ex && op == 2;
    e_alu = ex && !(op inside {0, 1, 2, 12, 13, 15});
    if (chk_en) begin
      chk("pc", 32'(bus.pc), 32'(mpc));
      chk("retired", 32'(bus.retired), 32'(mret));
      chk("ctl",
          {25'd0, bus.ir_ce, bus.ld_ce, bus.st_ce,
           bus.acc_ce, bus.cy_ce, bus.step_done,
           bus.halted},
          {25'd0, e_ir, e_ld, e_st, e_alu, e_alu,
           mdone, mhalt});
    end
    if (!rn) begin
      busy = 0; mstep = 0; mhalt = 0; mdone = 0;
      age = 0; mpc = 0; mret = 0; chk_en = 1;
    end else if (mhalt) begin
      mdone = 0;
    end else if (!busy) begin
      mdone = 0;
      if (r || s) begin
        busy = 1; age = 0; mstep = !r;
      end
    end else if (age < 2) begin
      age++;
      mdone = 0;
    end else if (op == 15) begin
      mhalt = 1; busy = 0; mdone = 0;
    end else begin
      mret = (mret + 1) % 256;
      if (op == 12 || (op == 13 && z))
        mpc = int'(rom_tg[mpc]);
      else
        mpc = (mpc + 1) % 32;
      if (r && !mstep) begin
        age = 0; mdone = 0;
      end else begin
        busy = 0; mdone = mstep; mstep = 0;
      end
    end
  endtask

  task automatic one_instr(input bit z);
    cyc(1, 0, z, 1);
    repeat (3) cyc(0, 0, z, 1);
  endtask

  task automatic post_chk(input string tag,
                          input int epc, input int eret);
    @(posedge clk);
    #1;
    chk({tag, "_pc"}, 32'(bus.pc), 32'(epc));
    chk({tag, "_ret"}, 32'(bus.retired), 32'(eret));
  endtask

  initial begin
    logic [15:0] irm, ldm, stm, acm;
    int en_cnt, h_cnt, dn_cnt;
    bus.run = 0; bus.step_req = 0; bus.acc_zero = 0;
    rst_n = 0; chk_en = 0;
    for (int i = 0; i < 32; i++) begin
      rom_op[i] = 4'h0; rom_tg[i] = 5'd0;
    end

    // 1: NOP, LD, ST, ADD in free-run
    rom_op[1] = 4'h1; rom_op[2] = 4'h2; rom_op[3] = 4'h8;
    cyc(1, 0, 0, 0);
    irm = 0; ldm = 0; stm = 0; acm = 0;
    for (int k = 0; k < 13; k++) begin
      cyc(1, 0, 0, 1);
      irm[k] = bus.ir_ce; ldm[k] = bus.ld_ce;
      stm[k] = bus.st_ce; acm[k] = bus.acc_ce & bus.cy_ce;
    end
    chk("t1_ir", 32'(irm), 32'h0492);
    chk("t1_ld", 32'(ldm), 32'h0040);
    chk("t1_st", 32'(stm), 32'h0200);
    chk("t1_acc", 32'(acm), 32'h1000);
    post_chk("t1", 4, 4);
    repeat (4) cyc(0, 0, 0, 1);

    // 2: pc 31 wraps to 0
    rom_op[1] = 0; rom_op[2] = 0; rom_op[3] = 0;
    rom_op[0] = 4'hC; rom_tg[0] = 5'd31;
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc(k < 6, 0, 0, 1);
    post_chk("t2", 0, 2);

    // 3: JZ taken / not taken, JMP ignores acc_zero
    cyc(0, 0, 0, 0);
    rom_op[0] = 4'hD; rom_tg[0] = 5'd5;
    one_instr(1);
    post_chk("t3a", 5, 1);
    rom_op[5] = 4'hD; rom_tg[5] = 5'd9;
    one_instr(0);
    post_chk("t3b", 6, 2);
    rom_op[6] = 4'hC; rom_tg[6] = 5'd17;
    one_instr(0);
    post_chk("t3c", 17, 3);
    rom_op[17] = 4'hC; rom_tg[17] = 5'd3;
    one_instr(1);
    post_chk("t3d", 3, 4);

    // 4: single step, step_req in DECODE ignored
    rom_op[3] = 4'h1;
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t4_done", 32'(bus.step_done), 1);
    cyc(0, 0, 0, 1);
    chk("t4_idle", 32'({bus.step_done, bus.ir_ce}), 0);
    // run and step together: run wins, no step_done
    dn_cnt = 0;
    cyc(1, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 0, 1);
      dn_cnt += int'(bus.step_done);
    end
    chk("t4_nodone", 32'(dn_cnt), 0);

    // 5: HALT freezes everything until reset
    rom_op[5] = 4'hF;
    repeat (4) cyc(1, 0, 0, 1);
    en_cnt = 0; h_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1'($urandom), 1'($urandom), 1);
      en_cnt += int'(bus.ir_ce | bus.ld_ce | bus.st_ce |
                     bus.acc_ce | bus.cy_ce);
      h_cnt += int'(bus.halted);
    end
    chk("t5_en", 32'(en_cnt), 0);
    chk("t5_halt", 32'(h_cnt), 20);
    chk("t5_pc", 32'(bus.pc), 5);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("t5_rst", 32'({bus.halted, 3'd0, bus.pc}), 0);

    // 6: reset during EXEC of LD
    rom_op[0] = 4'h1;
    repeat (3) cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    chk("t6_ld", 32'(bus.ld_ce), 0);
    cyc(1, 0, 0, 1);
    chk("t6_ir", 32'(bus.ir_ce), 1);
    repeat (3) cyc(0, 0, 0, 1);

    // retired wraps 255 -> 0
    for (int i = 0; i < 32; i++) rom_op[i] = 4'h0;
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 772; k++) cyc(k < 771, 0, 0, 1);
    post_chk("wrap", 1, 1);

    // random traffic
    for (int i = 0; i < 32; i++) begin
      rom_op[i] = 4'($urandom_range(0, 15));
      rom_tg[i] = 5'($urandom_range(0, 31));
    end
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(0, 9) < 7,
          $urandom_range(0, 4) == 0,
          1'($urandom),
          $urandom_range(0, 79) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
